// File: rtl/rs_symbol_delay_fifo_if.sv
// Symbol stream bundle for the RS delay FIFO: ready/valid input side, ready/valid output side,
// each symbol tagged with end-of-codeword.
interface rs_symbol_delay_fifo_if #(
  parameter int unsigned WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             in_eop;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_eop;

  modport master (
    output in_valid, in_data, in_eop, out_ready,
    input  in_ready, out_valid, out_data, out_eop
  );

  modport slave (
    input  in_valid, in_data, in_eop, out_ready,
    output in_ready, out_valid, out_data, out_eop
  );
endinterface

// File: rtl/rs_symbol_delay_fifo.sv
// Self-addressing symbol delay line for the RS decoder: holds symbols until a fill threshold is
// reached or a whole codeword is present, then streams them out through a registered RAM read.
module rs_symbol_delay_fifo #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned ADDR_W = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  flush,
  input  logic [ADDR_W:0]       cfg_delay,
  rs_symbol_delay_fifo_if.slave bus,
  output logic [ADDR_W:0]       count
);
  localparam int unsigned DEPTH = 1 << ADDR_W;
  localparam int unsigned CntW  = ADDR_W + 1;
  localparam logic [ADDR_W:0] DepthCnt = {1'b1, {ADDR_W{1'b0}}};

  typedef enum logic [0:0] {StFill, StStream} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] wp_q, wp_d, rp_q, rp_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic [ADDR_W:0]   eop_cnt_q, eop_cnt_d;
  logic [ADDR_W:0]   thr_q, thr_d;
  logic              out_valid_q, out_valid_d;
  logic [WIDTH-1:0]  out_data_q;
  logic              out_eop_q;

  logic [WIDTH:0]    mem [DEPTH];
  logic [DEPTH-1:0]  eop_tag;

  logic [ADDR_W:0]   cfg_thr;
  logic              in_ready_s;
  logic              wr_en, rd_en, rd_eop;
  logic              go_stream, streaming;

  always_comb begin
    cfg_thr    = (cfg_delay > DepthCnt) ? DepthCnt : cfg_delay;
    in_ready_s = count_q < DepthCnt;
    wr_en      = bus.in_valid && in_ready_s && !flush;

    // Leaving FILL takes effect in the same cycle so a symbol can be read one clock after it lands.
    go_stream  = (count_q != '0) && ((count_q >= thr_q) || (eop_cnt_q != '0));
    streaming  = (state_q == StStream) || go_stream;
    rd_en      = streaming && (count_q != '0) && (!out_valid_q || bus.out_ready) && !flush;
    rd_eop     = eop_tag[rp_q];

    wp_d      = wp_q + ADDR_W'(wr_en);
    rp_d      = rp_q + ADDR_W'(rd_en);
    count_d   = count_q + CntW'(wr_en) - CntW'(rd_en);
    eop_cnt_d = eop_cnt_q + CntW'(wr_en && bus.in_eop) - CntW'(rd_en && rd_eop);

    state_d = streaming ? StStream : StFill;
    thr_d   = thr_q;
    if (rd_en && rd_eop && (eop_cnt_d == '0)) begin
      state_d = StFill;
      thr_d   = cfg_thr;
    end

    out_valid_d = out_valid_q;
    if (rd_en) begin
      out_valid_d = 1'b1;
    end else if (bus.out_ready) begin
      out_valid_d = 1'b0;
    end

    if (flush) begin
      wp_d        = '0;
      rp_d        = '0;
      count_d     = '0;
      eop_cnt_d   = '0;
      state_d     = StFill;
      thr_d       = cfg_thr;
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= StFill;
      wp_q        <= '0;
      rp_q        <= '0;
      count_q     <= '0;
      eop_cnt_q   <= '0;
      thr_q       <= cfg_thr;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      wp_q        <= wp_d;
      rp_q        <= rp_d;
      count_q     <= count_d;
      eop_cnt_q   <= eop_cnt_d;
      thr_q       <= thr_d;
      out_valid_q <= out_valid_d;
    end
  end

  // eop bits are mirrored in flops so the FSM can see the tag of the entry being read this cycle.
  always_ff @(posedge clock) begin
    if (wr_en) begin
      mem[wp_q]     <= {bus.in_eop, bus.in_data};
      eop_tag[wp_q] <= bus.in_eop;
    end
  end

  // The RAM read port register doubles as the output register.
  always_ff @(posedge clock) begin
    if (reset || flush) begin
      out_data_q <= '0;
      out_eop_q  <= 1'b0;
    end else if (rd_en) begin
      {out_eop_q, out_data_q} <= mem[rp_q];
    end
  end

  assign bus.in_ready  = in_ready_s;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_eop   = out_eop_q;
  assign count         = count_q;
endmodule

// File: tb/tb_rs_symbol_delay_fifo.sv
// Directed bench for rs_symbol_delay_fifo: a cycle table for the threshold case, hand-written
// sequences for full, eop release, backpressure, flush and zero-delay streaming.
module tb_rs_symbol_delay_fifo;
  localparam int unsigned WIDTH  = 8;
  localparam int unsigned ADDR_W = 8;

  logic            clock = 1'b0;
  logic            reset;
  logic            flush;
  logic [ADDR_W:0] cfg_delay;
  logic [ADDR_W:0] count;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;
  int n_pop = 0;

  logic [WIDTH:0] exp_q[$];
  int             stamp_q[$];
  bit             chk_lat    = 1'b0;
  logic           prev_stall = 1'b0;
  logic [WIDTH:0] prev_word  = '0;

  typedef struct {
    logic            vin;
    logic [7:0]      din;
    logic            ordy;
    logic            exp_ov;
    logic [7:0]      exp_od;
    logic [ADDR_W:0] exp_cnt;
  } vec_t;

  vec_t vecs[21];

  rs_symbol_delay_fifo_if #(.WIDTH(WIDTH)) bus ();

  rs_symbol_delay_fifo #(
    .WIDTH (WIDTH),
    .ADDR_W(ADDR_W)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .flush    (flush),
    .cfg_delay(cfg_delay),
    .bus      (bus),
    .count    (count)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset(input logic [ADDR_W:0] cfg);
    cfg_delay     = cfg;
    reset         = 1'b1;
    flush         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_eop    = 1'b0;
    bus.out_ready = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic wait_drain(input string name, input int limit);
    int k = 0;
    while ((exp_q.size() != 0 || count != '0 || bus.out_valid) && k < limit) begin
      tick();
      k++;
    end
    check(name, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic write_sym(input logic [7:0] d, input logic e);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_eop   = e;
    tick();
  endtask

  // Scoreboard: inputs are stable at the falling edge and describe the upcoming rising edge.
  always @(negedge clock) begin
    if (reset || flush) begin
      exp_q.delete();
      stamp_q.delete();
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_valid", 32'(bus.out_valid), 32'd1);
        check("stall_data", 32'({bus.out_eop, bus.out_data}), 32'(prev_word));
      end
      if (bus.out_valid && bus.out_ready) begin
        n_pop++;
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL out_unexpected: got 0x%0h, want no output (t=%0t)",
                   {bus.out_eop, bus.out_data}, $time);
        end else begin
          check("out_order", 32'({bus.out_eop, bus.out_data}), 32'(exp_q.pop_front()));
          if (chk_lat) check("latency", 32'(cyc - stamp_q.pop_front()), 32'd2);
          else void'(stamp_q.pop_front());
        end
      end
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_word  = {bus.out_eop, bus.out_data};
      if (bus.in_valid && bus.in_ready) begin
        exp_q.push_back({bus.in_eop, bus.in_data});
        stamp_q.push_back(cyc);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want $finish");
    $fatal(1);
  end

  task automatic run_full(input logic [ADDR_W:0] cfg);
    int base;
    do_reset(cfg);
    for (int i = 0; i < 256; i++) write_sym(8'(i), 1'b0);
    check("full_count", 32'(count), 32'd256);
    check("full_in_ready", 32'(bus.in_ready), 32'd0);
    check("full_no_out", 32'(bus.out_valid), 32'd0);
    write_sym(8'hAA, 1'b0);  // held off: in_ready is low across this edge
    bus.in_valid = 1'b0;
    check("held_count", 32'(count), 32'd255);
    check("held_out_valid", 32'(bus.out_valid), 32'd1);
    check("held_out_data", 32'(bus.out_data), 32'h00);
    base = n_pop;
    bus.out_ready = 1'b1;
    wait_drain("full_drain", 600);
    check("full_pops", 32'(n_pop - base), 32'd256);
    base = n_pop;
    for (int i = 0; i < 5; i++) write_sym(8'hB0 + 8'(i), 1'b0);
    bus.in_valid = 1'b0;
    wait_drain("wrap_drain", 50);
    check("wrap_pops", 32'(n_pop - base), 32'd5);
  endtask

  initial begin
    int base;
    int seq;
    int k;
    logic acc;

    bus.in_data = '0;
    do_reset(9'd10);

    // Reset state
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_data", 32'(bus.out_data), 32'd0);
    check("rst_out_eop", 32'(bus.out_eop), 32'd0);
    check("rst_count", 32'(count), 32'd0);
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);

    // Threshold 10: nine symbols stay put, the tenth releases all ten
    for (int s = 0; s < 21; s++) begin
      vecs[s].ordy = 1'b1;
      if (s < 10) begin
        vecs[s].vin     = 1'b1;
        vecs[s].din     = 8'(s + 1);
        vecs[s].exp_ov  = 1'b0;
        vecs[s].exp_od  = 8'h00;
        vecs[s].exp_cnt = 9'(s + 1);
      end else if (s < 20) begin
        vecs[s].vin     = 1'b0;
        vecs[s].din     = 8'h00;
        vecs[s].exp_ov  = 1'b1;
        vecs[s].exp_od  = 8'(s - 9);
        vecs[s].exp_cnt = 9'(19 - s);
      end else begin
        vecs[s].vin     = 1'b0;
        vecs[s].din     = 8'h00;
        vecs[s].exp_ov  = 1'b0;
        vecs[s].exp_od  = 8'h0A;
        vecs[s].exp_cnt = 9'd0;
      end
    end
    for (int s = 0; s < 21; s++) begin
      bus.in_valid  = vecs[s].vin;
      bus.in_data   = vecs[s].din;
      bus.in_eop    = 1'b0;
      bus.out_ready = vecs[s].ordy;
      tick();
      check($sformatf("tbl%0d_out_valid", s), 32'(bus.out_valid), 32'(vecs[s].exp_ov));
      check($sformatf("tbl%0d_out_data", s), 32'(bus.out_data), 32'(vecs[s].exp_od));
      check($sformatf("tbl%0d_count", s), 32'(count), 32'(vecs[s].exp_cnt));
    end

    // Full, hold-off, wrap; then an oversized threshold that must clamp to DEPTH
    run_full(9'd256);
    run_full(9'd511);

    // eop releases a short codeword early, then the FSM is back in FILL
    do_reset(9'd200);
    bus.out_ready = 1'b1;
    base = n_pop;
    for (int i = 0; i < 5; i++) write_sym(8'h10 + 8'(i), i == 4);
    bus.in_valid = 1'b0;
    bus.in_eop   = 1'b0;
    wait_drain("eop_drain", 50);
    check("eop_pops", 32'(n_pop - base), 32'd5);
    check("eop_count", 32'(count), 32'd0);
    base = n_pop;
    for (int i = 0; i < 3; i++) write_sym(8'h20 + 8'(i), 1'b0);
    bus.in_valid = 1'b0;
    repeat (10) tick();
    check("refill_no_out", 32'(bus.out_valid), 32'd0);
    check("refill_count", 32'(count), 32'd3);
    check("refill_pops", 32'(n_pop - base), 32'd0);

    // Random backpressure, eop every seventh symbol
    do_reset(9'd4);
    seq = 0;
    for (int c = 0; c < 400; c++) begin
      bus.in_valid  = ($urandom % 10) < 7;
      bus.in_data   = 8'(seq);
      bus.in_eop    = (seq % 7) == 6;
      bus.out_ready = $urandom % 2;
      acc = bus.in_valid && bus.in_ready;
      tick();
      if (acc) seq++;
    end
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_data   = 8'(seq);
    bus.in_eop    = 1'b1;
    k = 0;
    while (!bus.in_ready && k < 100) begin
      tick();
      k++;
    end
    tick();
    bus.in_valid = 1'b0;
    bus.in_eop   = 1'b0;
    wait_drain("bp_drain", 600);

    // One symbol per clock once out_ready is held high
    do_reset(9'd0);
    for (int i = 0; i < 20; i++) write_sym(8'h60 + 8'(i), 1'b0);
    bus.in_valid = 1'b0;
    check("tp_count", 32'(count), 32'd19);
    check("tp_out_valid", 32'(bus.out_valid), 32'd1);
    base = n_pop;
    bus.out_ready = 1'b1;
    repeat (20) tick();
    check("tp_pops", 32'(n_pop - base), 32'd20);
    check("tp_empty", 32'(count), 32'd0);
    check("tp_idle", 32'(bus.out_valid), 32'd0);

    // Flush with 37 held plus one in the output register; coincident write is dropped
    do_reset(9'd0);
    for (int i = 0; i < 38; i++) write_sym(8'h40 + 8'(i), 1'b0);
    check("pre_flush_count", 32'(count), 32'd37);
    check("pre_flush_valid", 32'(bus.out_valid), 32'd1);
    flush = 1'b1;
    write_sym(8'hEE, 1'b0);
    flush        = 1'b0;
    bus.in_valid = 1'b0;
    check("flush_out_valid", 32'(bus.out_valid), 32'd0);
    check("flush_count", 32'(count), 32'd0);
    check("flush_in_ready", 32'(bus.in_ready), 32'd1);
    check("flush_out_data", 32'(bus.out_data), 32'd0);
    base = n_pop;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) write_sym(8'h51 + 8'(i), 1'b0);
    bus.in_valid = 1'b0;
    wait_drain("flush_drain", 50);
    check("flush_pops", 32'(n_pop - base), 32'd3);

    // Zero delay, continuous traffic: fixed 2-clock latency, at most one symbol held
    do_reset(9'd0);
    bus.out_ready = 1'b1;
    chk_lat = 1'b1;
    for (int i = 0; i < 30; i++) begin
      write_sym(8'h80 + 8'(i), 1'b0);
      check("z_count_le1", 32'(count <= 9'd1), 32'd1);
      if (i >= 1) check("z_out_valid", 32'(bus.out_valid), 32'd1);
    end
    bus.in_valid = 1'b0;
    wait_drain("z_drain", 20);
    chk_lat = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
